mdu_sched: RTL
==============

MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40: the maximum number of WAIT cycles before an operation is aborted.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0, req1  in  1  operation request from requester 0 (core) / 1 (interrupt context); held high until granted.
- op0, op1  in  2  operation: 00 shift-left, 01 multiply, 10 divide, 11 shift-right.
- mode0, mode1  in  1  signed mode for multiply/divide.
- a0, b0, a1, b1  in  16  operands.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, operands captured.
- done0, done1  out  1  one-cycle pulse: result valid on res.
- dz0, dz1  out  1  one-cycle pulse with done: divide by zero.
- to0, to1  out  1  one-cycle pulse with done: unit timeout.
- res  out  16  result; valid only while done0 or done1 is high.
- busy  out  1  high in every state except IDLE.
- u_start  out  1  start strobe to the shared mul/div/shift unit.
- u_op  out  2  operation to the unit.
- u_mode  out  1  signed mode to the unit.
- u_num1, u_num2  out  16  operands to the unit.
- u_rdy  in  1  unit result strobe.
- u_res  in  16  unit result.

Function
REQ-003 The block SHALL implement a four-state machine with states IDLE, ISSUE, WAIT and DONE.
REQ-004 In IDLE, when any request is high, the block SHALL capture the winner's op, mode, a and b into registers, pulse the winner's gnt in that same cycle, and move to ISSUE on the next edge.
REQ-005 Arbitration SHALL be round-robin: if only one requester is high, it wins; if both are high, the requester that was not the last owner wins; last_owner SHALL reset to 1, so req0 wins the first tie.
REQ-006 A divide request with b==0 SHALL bypass the unit:
- the block goes IDLE->DONE directly;
- res=16'hFFFF;
- dz of that owner pulses together with its done.
REQ-007 In ISSUE, u_start SHALL be high for exactly one cycle, with u_op, u_mode, u_num1 and u_num2 driven from the captured registers; the next state SHALL be WAIT.
REQ-008 u_op, u_mode, u_num1 and u_num2 SHALL remain stable from ISSUE through WAIT, and SHALL be zero in IDLE.
REQ-009 In WAIT, when u_rdy is high, the block SHALL register u_res into res and go to DONE.
REQ-010 In WAIT, the block SHALL count cycles; if the count reaches TIMEOUT without u_rdy, it SHALL go to DONE with res=0 and pulse the owner's to.
REQ-011 If u_rdy and the timeout occur in the same cycle, u_rdy SHALL win and to SHALL stay low.
REQ-012 In DONE, the owner's done SHALL be high for exactly one cycle, and the next state SHALL be IDLE.
REQ-013 A new request SHALL NOT be accepted in DONE; the minimum spacing between two accepted requests is therefore 4 cycles for unit operations and 2 cycles for divide-by-zero.
REQ-014 u_rdy SHALL be ignored outside WAIT.
REQ-015 Deasserting a request before its gnt SHALL cancel it with no side effects.
REQ-016 Request lines SHALL be ignored after gnt until DONE has completed.
REQ-017 Shift operands SHALL be passed through unmodified; shift count encoding is owned by the unit.

Reset
REQ-018 While rst is high at a clock edge, the block SHALL:
- enter IDLE;
- clear all captured registers, res and the timeout counter;
- set last_owner=1;
- drive every output to 0.
REQ-019 Reset asserted mid-operation (ISSUE, WAIT or DONE) SHALL abort the operation with no done pulse; a late u_rdy after reset SHALL be ignored.

Structure
REQ-020 Package mdu_pkg SHALL hold the op encodings (OP_SHL=00, OP_MUL=01, OP_DIV=10, OP_SHR=11), the state enum, and the TIMEOUT default.
REQ-021 Round-robin selection SHALL be a sub-module rr_arb2, with inputs req[1:0] and last_owner and a one-hot output win[1:0].
REQ-022 The FSM, operand capture and timeout counter SHALL live in mdu_sched.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- req0 multiply a0=7, b0=6, unit returns 42 three cycles after u_start -> gnt0 in the request cycle, u_start one cycle later, done0 with res=42, busy low the following cycle.
- req0 and req1 both high after reset -> requester 0 served first, requester 1 served next without re-arbitration loss; a third simultaneous tie goes to requester 0.
- req1 divide a1=100, b1=0 -> no u_start, done1 and dz1 one cycle after gnt1, res=16'hFFFF.
- unit never asserts u_rdy, TIMEOUT=40 -> done0 and to0 after 40 WAIT cycles, res=0; u_rdy on exactly cycle 40 -> to0 low, res=u_res.
- rst pulsed during WAIT, then u_rdy -> no done pulse, state IDLE, all outputs 0.
- req0 dropped in the same cycle rst releases, stray u_rdy in IDLE -> no gnt, no done, busy stays low.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_pkg : op encodings, scheduler states and default unit timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin pick; on a tie the previous owner loses
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arb2
  import mdu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win
);

  assign win[0] = req[0] & (~req[1] | last_owner);
  assign win[1] = req[1] & (~req[0] | ~last_owner);

endmodule
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_sched : arbitrates two requesters onto one shared mul/div/shift unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        dz0,
  output logic        dz1,
  output logic        to0,
  output logic        to1,
  output logic [15:0] res,
  output logic        busy,
  output logic        u_start,
  output logic [1:0]  u_op,
  output logic        u_mode,
  output logic [15:0] u_num1,
  output logic [15:0] u_num2,
  input  logic        u_rdy,
  input  logic [15:0] u_res
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q,  last_d;
  logic [1:0]         op_q,    op_d;
  logic               mode_q,  mode_d;
  logic [15:0]        a_q,     a_d;
  logic [15:0]        b_q,     b_d;
  logic [15:0]        res_q,   res_d;
  logic               dz_q,    dz_d;
  logic               to_q,    to_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         win;
  logic [1:0]         gnt_w;
  logic               start_w;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_owner (last_q),
    .win        (win)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    dz_d    = dz_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    gnt_w   = 2'b00;
    start_w = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          gnt_w   = win;
          owner_d = win[1];
          last_d  = win[1];
          op_d    = win[1] ? op1   : op0;
          mode_d  = win[1] ? mode1 : mode0;
          a_d     = win[1] ? a1    : a0;
          b_d     = win[1] ? b1    : b0;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          // Divide by zero never reaches the unit.
          if (op_d == OP_DIV && b_d == 16'h0000) begin
            res_d   = 16'hFFFF;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        start_w = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (u_rdy) begin
          res_d   = u_res;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = 16'h0000;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 2'b00;
      mode_q  <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held, whatever state is registered.
  logic run, in_done, unit_en;
  assign run     = ~rst;
  assign in_done = run & (state_q == DONE);
  assign unit_en = run & ((state_q == ISSUE) | (state_q == WAIT));

  assign gnt0    = run & gnt_w[0];
  assign gnt1    = run & gnt_w[1];
  assign done0   = in_done & ~owner_q;
  assign done1   = in_done &  owner_q;
  assign dz0     = done0 & dz_q;
  assign dz1     = done1 & dz_q;
  assign to0     = done0 & to_q;
  assign to1     = done1 & to_q;
  assign res     = run ? res_q : 16'h0000;
  assign busy    = run & (state_q != IDLE);
  assign u_start = run & start_w;
  assign u_op    = unit_en ? op_q   : 2'b00;
  assign u_mode  = unit_en & mode_q;
  assign u_num1  = unit_en ? a_q    : 16'h0000;
  assign u_num2  = unit_en ? b_q    : 16'h0000;

endmodule
`default_nettype wire
